// File: rtl/rs232_pkg.sv
// Shared register map, status bit positions and FSM encodings for the
// RS232 Avalon-MM UART.
package rs232_pkg;

    localparam logic [4:0] RX_BASE     = 5'd0;
    localparam logic [4:0] TX_BASE     = 5'd4;
    localparam logic [4:0] STATUS_BASE = 5'd8;

    localparam int RRDY_BIT = 7;
    localparam int TRDY_BIT = 6;
    localparam int TMT_BIT  = 5;
    localparam int TOE_BIT  = 4;
    localparam int ROE_BIT  = 3;
    localparam int FE_BIT   = 1;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

endpackage

// File: rtl/rs232_rx_deser.sv
// 8N1 receiver: input synchroniser, mid-bit sampling FSM and baud counter.
// Emits the received byte with a one-cycle valid pulse, or a frame-error pulse.
module rs232_rx_deser
    import rs232_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rxd_i,
    output logic [7:0] data_o,
    output logic       vld_o,
    output logic       fe_o
);

    localparam logic [15:0] BIT_LAST  = 16'(BAUD_DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);

    // [0],[1] synchroniser, [2] previous synchronised value for edge detect
    logic [2:0]  sync_q;
    rx_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  sr_q, sr_d;
    logic        vld_q, vld_d, fe_q, fe_d;
    logic        rxs, fall;

    assign rxs  = sync_q[1];
    assign fall = sync_q[2] & ~sync_q[1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= 3'b111;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sr_q    <= '0;
            vld_q   <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            sync_q  <= {sync_q[1:0], rxd_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            vld_q   <= vld_d;
            fe_q    <= fe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - 16'd1 : cnt_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        vld_d   = 1'b0;
        fe_d    = 1'b0;
        unique case (state_q)
            RX_IDLE: if (fall) begin
                cnt_d   = HALF_LAST;
                state_d = RX_START;
            end
            RX_START: if (cnt_q == '0) begin
                // line back high at mid start bit: treat as a glitch
                if (!rxs) begin
                    cnt_d   = BIT_LAST;
                    bit_d   = '0;
                    state_d = RX_DATA;
                end else begin
                    state_d = RX_IDLE;
                end
            end
            RX_DATA: if (cnt_q == '0) begin
                sr_d  = {rxs, sr_q[7:1]};
                cnt_d = BIT_LAST;
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = RX_STOP;
            end
            RX_STOP: if (cnt_q == '0) begin
                vld_d   = rxs;
                fe_d    = ~rxs;
                state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign data_o = sr_q;
    assign vld_o  = vld_q;
    assign fe_o   = fe_q;

endmodule

// File: rtl/rs232_avs_uart.sv
// Avalon-MM slave UART: RX/TX/STATUS registers, two-cycle ack handshake and
// the 8N1 transmitter; the receiver lives in rs232_rx_deser.
module rs232_avs_uart
    import rs232_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic        avm_clk,
    input  logic        avm_rst,
    input  logic [4:0]  avs_address,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic        avs_waitrequest,
    input  logic        uart_rxd,
    output logic        uart_txd
);

    localparam logic [15:0] BIT_LAST = 16'(BAUD_DIV - 1);

    logic        ack_q, ack_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        rrdy_q, rrdy_d, trdy_q, trdy_d, tmt_q, tmt_d;
    logic        toe_q, toe_d, roe_q, roe_d, fe_q, fe_d;
    logic [7:0]  rxbuf_q, rxbuf_d, txhold_q, txhold_d;
    tx_state_e   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_sr_q, tx_sr_d;
    logic        txd_q, txd_d;
    logic        tx_load, wr_done, rd_rx_done;
    logic [7:0]  status, rx_byte;
    logic        rx_vld, rx_fe;
    logic        unused_wdata;

    assign unused_wdata = ^avs_writedata[31:8];

    rs232_rx_deser #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk_i  (avm_clk),
        .rst_ni (avm_rst),
        .rxd_i  (uart_rxd),
        .data_o (rx_byte),
        .vld_o  (rx_vld),
        .fe_o   (rx_fe)
    );

    always_ff @(posedge avm_clk or negedge avm_rst) begin
        if (!avm_rst) begin
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            rrdy_q     <= 1'b0;
            trdy_q     <= 1'b1;
            tmt_q      <= 1'b1;
            toe_q      <= 1'b0;
            roe_q      <= 1'b0;
            fe_q       <= 1'b0;
            rxbuf_q    <= '0;
            txhold_q   <= '0;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sr_q    <= '0;
            txd_q      <= 1'b1;
        end else begin
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            rrdy_q     <= rrdy_d;
            trdy_q     <= trdy_d;
            tmt_q      <= tmt_d;
            toe_q      <= toe_d;
            roe_q      <= roe_d;
            fe_q       <= fe_d;
            rxbuf_q    <= rxbuf_d;
            txhold_q   <= txhold_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sr_q    <= tx_sr_d;
            txd_q      <= txd_d;
        end
    end

    always_comb begin
        status           = '0;
        status[RRDY_BIT] = rrdy_q;
        status[TRDY_BIT] = trdy_q;
        status[TMT_BIT]  = tmt_q;
        status[TOE_BIT]  = toe_q;
        status[ROE_BIT]  = roe_q;
        status[FE_BIT]   = fe_q;
    end

    always_comb begin
        wr_done    = ack_q & avs_write;
        rd_rx_done = ack_q & avs_read & ~avs_write & (avs_address == RX_BASE);
        ack_d      = (avs_read | avs_write) & ~ack_q;
        rdata_d    = '0;
        if (ack_d && !avs_write) begin
            case (avs_address)
                RX_BASE:     rdata_d = rxbuf_q;
                STATUS_BASE: rdata_d = status;
                default:     rdata_d = '0;
            endcase
        end

        rrdy_d     = rrdy_q;
        trdy_d     = trdy_q;
        tmt_d      = tmt_q;
        toe_d      = toe_q;
        roe_d      = roe_q;
        fe_d       = fe_q;
        rxbuf_d    = rxbuf_q;
        txhold_d   = txhold_q;
        tx_state_d = tx_state_q;
        tx_cnt_d   = (tx_cnt_q != '0) ? tx_cnt_q - 16'd1 : tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_sr_d    = tx_sr_q;
        txd_d      = txd_q;
        tx_load    = 1'b0;

        unique case (tx_state_q)
            TX_IDLE:  tx_load = ~trdy_q;
            TX_START: if (tx_cnt_q == '0) begin
                txd_d      = tx_sr_q[0];
                tx_sr_d    = tx_sr_q >> 1;
                tx_bit_d   = '0;
                tx_cnt_d   = BIT_LAST;
                tx_state_d = TX_DATA;
            end
            TX_DATA: if (tx_cnt_q == '0) begin
                tx_cnt_d = BIT_LAST;
                if (tx_bit_q == 3'd7) begin
                    txd_d      = 1'b1;
                    tx_state_d = TX_STOP;
                end else begin
                    txd_d    = tx_sr_q[0];
                    tx_sr_d  = tx_sr_q >> 1;
                    tx_bit_d = tx_bit_q + 3'd1;
                end
            end
            TX_STOP: if (tx_cnt_q == '0) begin
                // a waiting hold byte follows with no idle gap
                if (!trdy_q) begin
                    tx_load = 1'b1;
                end else begin
                    tmt_d      = 1'b1;
                    tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase

        if (tx_load) begin
            tx_sr_d    = txhold_q;
            txd_d      = 1'b0;
            tx_cnt_d   = BIT_LAST;
            tx_state_d = TX_START;
            trdy_d     = 1'b1;
            tmt_d      = 1'b0;
        end

        if (wr_done && avs_address == STATUS_BASE) begin
            toe_d = 1'b0;
            roe_d = 1'b0;
            fe_d  = 1'b0;
        end
        if (wr_done && avs_address == TX_BASE) begin
            if (trdy_q || tx_load) begin
                txhold_d = avs_writedata[7:0];
                trdy_d   = 1'b0;
            end else begin
                toe_d = 1'b1;
            end
        end

        if (rd_rx_done) rrdy_d = 1'b0;
        if (rx_vld) begin
            rxbuf_d = rx_byte;
            rrdy_d  = 1'b1;
            if (rrdy_q && !rd_rx_done) roe_d = 1'b1;
        end
        if (rx_fe) fe_d = 1'b1;
    end

    assign avs_waitrequest = ~ack_q;
    assign avs_readdata    = {24'h0, rdata_q};
    assign uart_txd        = txd_q;

endmodule

// File: tb/tb_rs232_avs_uart.sv
// Scoreboard bench for rs232_avs_uart: a timeline model of the register file
// and serial links predicts read data and transmitted frames.
module tb_rs232_avs_uart;

    localparam int B = 8;

    logic        avm_clk = 1'b0;
    logic        avm_rst = 1'b1;
    logic [4:0]  avs_address = '0;
    logic        avs_read = 1'b0, avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic        uart_rxd = 1'b1;
    logic        uart_txd;

    rs232_avs_uart #(.BAUD_DIV(B)) dut (
        .avm_clk        (avm_clk),
        .avm_rst        (avm_rst),
        .avs_address    (avs_address),
        .avs_read       (avs_read),
        .avs_readdata   (avs_readdata),
        .avs_write      (avs_write),
        .avs_writedata  (avs_writedata),
        .avs_waitrequest(avs_waitrequest),
        .uart_rxd       (uart_rxd),
        .uart_txd       (uart_txd)
    );

    always #5 avm_clk = ~avm_clk;

    int unsigned edge_n = 0;
    always @(posedge avm_clk) edge_n <= edge_n + 1;

    int n_chk = 0, n_pass = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", nm, act, exp, edge_n);
    endtask

    // Reference model: flags, RX buffer, and a timeline of accepted TX bytes
    // (w = edge the write completed, L = edge the frame starts on the wire).
    typedef struct { logic [7:0] d; int unsigned w; int unsigned L; } txf_t;
    txf_t        txm[$];
    txf_t        tx_exp[$];
    logic [31:0] rd_exp[$];
    bit          m_rrdy, m_toe, m_roe, m_fe;
    logic [7:0]  m_rxbuf;

    function automatic bit m_trdy(int unsigned e);
        foreach (txm[i]) if (txm[i].w <= e && e < txm[i].L) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_tmt(int unsigned e);
        foreach (txm[i]) if (txm[i].L <= e && e < txm[i].L + 10 * B) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_status(int unsigned e);
        return {24'h0, m_rrdy, m_trdy(e), m_tmt(e), m_toe, m_roe, 1'b0, m_fe, 1'b0};
    endfunction

    task automatic model_write(logic [4:0] a, logic [7:0] d, int unsigned w);
        txf_t f;
        bit   busy = 1'b0;
        if (a == 5'd8) begin m_toe = 0; m_roe = 0; m_fe = 0; end
        if (a == 5'd4) begin
            foreach (txm[i]) if (txm[i].w < w && txm[i].L > w) busy = 1'b1;
            if (busy) m_toe = 1;
            else begin
                f.d = d; f.w = w; f.L = w + 1;
                if (txm.size() != 0 && txm[$].L + 10 * B > f.L) f.L = txm[$].L + 10 * B;
                txm.push_back(f);
                tx_exp.push_back(f);
            end
        end
    endtask

    // Caller is always at posedge+#1; returns at posedge+#1.
    task automatic bus(string nm, bit rd, bit wr, logic [4:0] a, logic [31:0] wd);
        int unsigned k = edge_n;
        if (rd) begin
            if (wr)             rd_exp.push_back(32'h0);
            else if (a == 5'd0) rd_exp.push_back({24'h0, m_rxbuf});
            else if (a == 5'd8) rd_exp.push_back(m_status(k));
            else                rd_exp.push_back(32'h0);
        end
        if (wr) model_write(a, wd[7:0], k + 2);
        else if (rd && a == 5'd0) m_rrdy = 0;
        avs_address = a; avs_read = rd; avs_write = wr; avs_writedata = wd;
        @(posedge avm_clk); #1;
        chk({nm, "_wait_low"}, {31'b0, avs_waitrequest}, 32'h0);
        @(posedge avm_clk); #1;
        chk({nm, "_wait_high"}, {31'b0, avs_waitrequest}, 32'h1);
        avs_read = 0; avs_write = 0; avs_address = '0; avs_writedata = '0;
    endtask

    task automatic send_rx(logic [7:0] d, bit stop_ok);
        logic [9:0] fr = {stop_ok, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rxd = fr[i];
            repeat (B) @(posedge avm_clk);
            #1;
        end
        uart_rxd = 1'b1;
        repeat (2 * B) @(posedge avm_clk);
        #1;
        if (stop_ok) begin
            if (m_rrdy) m_roe = 1;
            m_rxbuf = d; m_rrdy = 1;
        end else m_fe = 1;
    endtask

    task automatic wait_tx_idle();
        int t = 0;
        while ((tx_exp.size() != 0 || !m_tmt(edge_n)) && t < 4000) begin
            @(posedge avm_clk); #1; t++;
        end
        if (t >= 4000) begin
            n_chk++;
            $display("FAIL tx_drain_timeout: %0d frames pending after %0d cycles", tx_exp.size(), t);
        end
        repeat (2) @(posedge avm_clk);
        #1;
    endtask

    task automatic model_reset();
        txm.delete(); tx_exp.delete(); rd_exp.delete();
        m_rrdy = 0; m_toe = 0; m_roe = 0; m_fe = 0; m_rxbuf = '0;
    endtask

    always @(negedge avm_clk) begin
        if (avm_rst && avs_read && !avs_waitrequest) begin
            if (rd_exp.size() == 0) begin
                n_chk++;
                $display("FAIL rd_unexpected: readdata 0x%0h with nothing expected", avs_readdata);
            end else chk("readdata", avs_readdata, rd_exp.pop_front());
        end
    end

    txf_t mf;
    bit   m_ab, m_bad;
    logic m_eb;
    always begin
        @(posedge avm_clk); #1;
        if (avm_rst && uart_txd === 1'b0) begin
            if (tx_exp.size() == 0) begin
                n_chk++;
                $display("FAIL tx_spurious: start bit at edge %0d with no frame expected", edge_n);
                repeat (10 * B) @(posedge avm_clk);
            end else begin
                mf = tx_exp.pop_front();
                chk("tx_start_edge", edge_n, mf.L);
                m_ab = 0;
                for (int b = 0; b < 10 && !m_ab; b++) begin
                    m_eb  = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : mf.d[b-1];
                    m_bad = 0;
                    for (int c = 0; c < B && !m_ab; c++) begin
                        if (b != 0 || c != 0) begin @(posedge avm_clk); #1; end
                        if (!avm_rst) m_ab = 1;
                        else if (uart_txd !== m_eb) m_bad = 1;
                    end
                    if (!m_ab) chk($sformatf("tx_%02h_bit%0d", mf.d, b),
                                   {31'b0, m_bad ? ~m_eb : m_eb}, {31'b0, m_eb});
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #2 avm_rst = 1'b0;
        #1;
        chk("rst_waitrequest", {31'b0, avs_waitrequest}, 32'h1);
        chk("rst_readdata", avs_readdata, 32'h0);
        chk("rst_txd", {31'b0, uart_txd}, 32'h1);
        repeat (3) @(posedge avm_clk);
        #1 avm_rst = 1'b1;
        @(posedge avm_clk); #1;

        bus("status_reset", 1, 0, 5'd8, 0);

        send_rx(8'hA5, 1);
        bus("status_rrdy", 1, 0, 5'd8, 0);
        bus("rx_a5", 1, 0, 5'd0, 0);
        bus("status_cleared", 1, 0, 5'd8, 0);

        bus("tx_3c", 0, 1, 5'd4, 32'hFFFF_FF3C);
        bus("status_trdy_low", 1, 0, 5'd8, 0);
        bus("status_trdy_back", 1, 0, 5'd8, 0);
        wait_tx_idle();
        bus("status_tmt", 1, 0, 5'd8, 0);

        bus("tx_33", 0, 1, 5'd4, 32'h33);
        bus("tx_11", 0, 1, 5'd4, 32'h11);
        bus("tx_22", 0, 1, 5'd4, 32'h22);
        bus("status_toe", 1, 0, 5'd8, 0);
        bus("clr_status", 0, 1, 5'd8, 32'h0);
        bus("status_toe_clr", 1, 0, 5'd8, 0);
        wait_tx_idle();

        send_rx(8'h01, 1);
        send_rx(8'h02, 1);
        bus("status_roe", 1, 0, 5'd8, 0);
        bus("rx_02", 1, 0, 5'd0, 0);
        send_rx(8'h7E, 0);
        bus("status_fe", 1, 0, 5'd8, 0);
        bus("rx_stale", 1, 0, 5'd0, 0);
        bus("rd_wr_status", 1, 1, 5'd8, 32'hFF);
        bus("status_after_rw", 1, 0, 5'd8, 0);

        bus("unmapped_rd", 1, 0, 5'd16, 0);
        bus("unmapped_wr", 0, 1, 5'd12, 32'h55);
        bus("status_unmapped", 1, 0, 5'd8, 0);

        repeat (24) begin
            case ($urandom_range(0, 4))
                0: send_rx(8'($urandom), $urandom_range(0, 5) != 0);
                1: bus("rnd_rx", 1, 0, 5'd0, 0);
                2: bus("rnd_status", 1, 0, 5'd8, 0);
                3: bus("rnd_tx", 0, 1, 5'd4, $urandom);
                default: bus("rnd_clr", 0, 1, 5'd8, $urandom);
            endcase
        end
        wait_tx_idle();
        bus("status_rnd_end", 1, 0, 5'd8, 0);

        bus("tx_5a", 0, 1, 5'd4, 32'h5A);
        repeat (35) @(posedge avm_clk);
        #3 avm_rst = 1'b0;
        #1;
        chk("midframe_txd", {31'b0, uart_txd}, 32'h1);
        chk("midframe_wait", {31'b0, avs_waitrequest}, 32'h1);
        model_reset();
        repeat (3) @(posedge avm_clk);
        #1 avm_rst = 1'b1;
        @(posedge avm_clk); #1;
        bus("status_after_rst", 1, 0, 5'd8, 0);
        bus("rx_after_rst", 1, 0, 5'd0, 0);
        repeat (20 * B) @(posedge avm_clk);
        #1;
        chk("idle_txd_after_rst", {31'b0, uart_txd}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rs232_avs_uart.md
Name: rs232_avs_uart

Overview:
- Avalon-MM slave UART core that the RS232 echo master polls.
- Exposes three word registers: RX data at byte address 0, TX data at 4, STATUS at 8.
- Serialises and deserialises 8N1 frames on uart_txd / uart_rxd at a fixed baud divisor.
- Sits directly between the polling master and the board RS232 pins.

Parameters:
- BAUD_DIV, 434, avm_clk cycles per bit (50 MHz / 115200); legal range 4..65535.

Ports:
- avm_clk  in  1  system clock
- avm_rst  in  1  asynchronous active-low reset
- avs_address  in  5  byte address; only 0, 4, 8 decoded, others read 0 and ignore writes
- avs_read  in  1  read request
- avs_readdata  out  32  read data; upper 24 bits always 0
- avs_write  in  1  write request
- avs_writedata  in  32  write data; bits [7:0] used
- avs_waitrequest  out  1  stall; access completes in the cycle it is low
- uart_rxd  in  1  serial input, idle high, asynchronous
- uart_txd  out  1  serial output, idle high

Behaviour:
- Reset values (avm_rst low, immediate):
  - avs_waitrequest=1, avs_readdata=0, uart_txd=1.
  - RX state IDLE, TX state IDLE.
  - All status flags 0 except TRDY=1 and TMT=1.
- Bus handshake:
  - Internal ack flop. When (avs_read|avs_write) && !ack, ack<=1; otherwise ack<=0.
  - avs_waitrequest = !ack. Every access therefore completes in its second cycle, and waitrequest returns high the cycle after.
  - avs_readdata is registered, loaded in the same edge that sets ack, so it is valid while waitrequest is low.
  - Read and write asserted together: write has priority and readdata=0.
  - Side effects fire only on the completing cycle (ack=1).
- STATUS bits: 7 RRDY, 6 TRDY, 5 TMT, 4 TOE, 3 ROE, 1 FE; other bits 0.
  - A write to STATUS clears TOE, ROE and FE, regardless of writedata.
- RX data read: returns rxbuf in [7:0] and clears RRDY on completion.
- TX data write:
  - If TRDY=1: txhold<=data and TRDY<=0.
  - If TRDY=0: data is dropped and TOE<=1.
- RX path:
  - uart_rxd passes through a 2-flop synchroniser.
  - IDLE: a falling edge starts a BAUD_DIV/2 count, then state START.
  - START: if the line is still low, enter DATA; otherwise return to IDLE (glitch reject).
  - DATA: 8 samples, one every BAUD_DIV cycles at bit centre, LSB first.
  - STOP: sample the stop bit. If it is 0, set FE and discard the byte. If it is 1, rxbuf<=byte and RRDY<=1; if RRDY was already 1, also set ROE and overwrite rxbuf.
  - Return to IDLE after the stop sample.
- TX path:
  - IDLE: when txhold is full, load the shifter and set TRDY<=1 (hold freed), TMT<=0.
  - Frame is start bit 0, 8 data bits LSB first, stop bit 1, each BAUD_DIV cycles.
  - After the stop bit: if hold is full, start the next frame back-to-back with no idle gap; otherwise set TMT<=1.
- Simultaneous events:
  - A frame completing on the same cycle as an RX read: the new byte wins, RRDY stays 1 and ROE is not set.
  - A TX write landing on the same cycle the shifter frees hold is accepted.
- Reset mid-frame: everything is aborted at once, uart_txd goes high, and no partial byte is retained.

Decomposition:
- Package rs232_pkg:
  - RX_BASE=0, TX_BASE=4, STATUS_BASE=8
  - bit indices RRDY_BIT=7, TRDY_BIT=6, TMT_BIT=5, TOE_BIT=4, ROE_BIT=3, FE_BIT=1
  - RX/TX state encodings
- Sub-module rs232_rx_deser: synchroniser, RX FSM and baud counter. Outputs a byte with a one-cycle valid pulse and a frame-error pulse.
- The top level holds the register file, the ack handshake and the TX FSM inline.

Test Plan (BAUD_DIV=8):
1. Reset, then read STATUS -> waitrequest low exactly on cycle 2 of the access; readdata=0x60. Next cycle waitrequest high.
2. Drive serial frame 0xA5 on uart_rxd -> RRDY=1 (STATUS=0xE0). Read RX -> 0x000000A5. Re-read STATUS -> 0x60.
3. Write TX 0x3C -> TRDY drops then re-rises one cycle later. uart_txd shows 0, then 0,0,1,1,1,1,0,0, then 1, each 8 cycles wide. TMT=1 after the stop bit.
4. Write 0x11 and then 0x22 while TRDY=0 -> 0x22 dropped and TOE=1 (STATUS bit 4). Write STATUS -> TOE=0.
5. Send two RX frames 0x01 and 0x02 without a read -> ROE=1 and RX reads 0x02. Send a frame with stop bit 0 -> FE=1 and RRDY unchanged.
6. Assert avm_rst mid TX frame -> uart_txd=1 immediately. After release, STATUS=0x60 and there is no spurious frame.
